// File: rtl/memory_writer_wiener.sv
// rtl/memory_writer_wiener.sv - block-ordered pixel stream to raster-layout AXI4 write bursts
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_height/width    frame geometry in pixels, sampled on start_of_frame
//   base_addr_in          frame byte base address, sampled on start_of_frame
//   start_of_frame        arms a new frame (ignored unless idle)
//   data_in/valid/ready   block-ordered filtered pixel input
//   aw*, w*, b*           AXI4 write address, data and response channels
//   frame_done            one-cycle pulse after the last response of a frame
//   write_error           sticky flag, set on any non-OKAY response
module memory_writer_wiener #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             frame_height,
  input  logic [15:0]             frame_width,
  input  logic [ADDR_WIDTH-1:0]   base_addr_in,
  input  logic                    start_of_frame,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    frame_done,
  output logic                    write_error
);

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(BLOCK_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {IDLE, FILL, AW, W, B} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [15:0]           width_q;
  logic [15:0]           blocks_x;
  logic [15:0]           blocks_y;
  logic [15:0]           blk_row;
  logic [15:0]           blk_col;
  logic [IW-1:0]         row_in_blk;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         beat;
  logic [DATA_WIDTH-1:0] row_buf [BLOCK_SIZE];

  logic [15:0]           sof_bx;
  logic [15:0]           sof_by;
  logic [IW-1:0]         beat_nx;
  logic                  last_burst;
  logic [ADDR_WIDTH-1:0] pix_row;
  logic [ADDR_WIDTH-1:0] pix_off;
  logic [ADDR_WIDTH-1:0] burst_addr;

  assign awlen   = 8'(BLOCK_SIZE - 1);
  assign awsize  = 3'(SIZE_LOG2);
  assign awburst = 2'b01;
  assign wstrb   = '1;

  assign sof_bx  = frame_width / 16'(BLOCK_SIZE);
  assign sof_by  = frame_height / 16'(BLOCK_SIZE);
  assign beat_nx = beat + IW'(1);

  // Final row of the final block of the frame: counters wrap all the way round.
  assign last_burst = (row_in_blk == LAST_IDX) && (blk_col == blocks_x - 16'd1) &&
                      (blk_row == blocks_y - 16'd1);

  // Raster byte address of the row segment held in the buffer; wraps at ADDR_WIDTH.
  always_comb begin
    pix_row    = ADDR_WIDTH'(blk_row) * ADDR_WIDTH'(BLOCK_SIZE) + ADDR_WIDTH'(row_in_blk);
    pix_off    = pix_row * ADDR_WIDTH'(width_q) + ADDR_WIDTH'(blk_col) * ADDR_WIDTH'(BLOCK_SIZE);
    burst_addr = base + (pix_off << SIZE_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      width_q     <= '0;
      blocks_x    <= '0;
      blocks_y    <= '0;
      blk_row     <= '0;
      blk_col     <= '0;
      row_in_blk  <= '0;
      idx         <= '0;
      beat        <= '0;
      data_ready  <= 1'b0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wlast       <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      frame_done  <= 1'b0;
      write_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_of_frame) begin
            base       <= base_addr_in;
            width_q    <= frame_width;
            blocks_x   <= sof_bx;
            blocks_y   <= sof_by;
            blk_row    <= '0;
            blk_col    <= '0;
            row_in_blk <= '0;
            idx        <= '0;
            if (sof_bx != 16'd0 && sof_by != 16'd0) begin
              state      <= FILL;
              data_ready <= 1'b1;
            end else begin
              // Nothing to write: report completion immediately.
              frame_done <= 1'b1;
            end
          end
        end
        FILL: begin
          if (data_valid && data_ready) begin
            row_buf[idx] <= data_in;
            if (idx == LAST_IDX) begin
              idx        <= '0;
              data_ready <= 1'b0;
              awaddr     <= burst_addr;
              awvalid    <= 1'b1;
              state      <= AW;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= row_buf[0];
            wlast   <= 1'b0;
            beat    <= '0;
            state   <= W;
          end
        end
        W: begin
          if (wready) begin
            if (beat == LAST_IDX) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= B;
            end else begin
              beat  <= beat_nx;
              wdata <= row_buf[beat_nx];
              wlast <= (beat_nx == LAST_IDX);
            end
          end
        end
        B: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) write_error <= 1'b1;
            // Stream order: rows within a block, then blocks across, then block rows down.
            if (row_in_blk == LAST_IDX) begin
              row_in_blk <= '0;
              if (blk_col == blocks_x - 16'd1) begin
                blk_col <= '0;
                if (blk_row == blocks_y - 16'd1) blk_row <= '0;
                else blk_row <= blk_row + 16'd1;
              end else begin
                blk_col <= blk_col + 16'd1;
              end
            end else begin
              row_in_blk <= row_in_blk + IW'(1);
            end
            if (last_burst) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              data_ready <= 1'b1;
              state      <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writer_wiener.sv
// tb/tb_memory_writer_wiener.sv - directed bench for memory_writer_wiener
`timescale 1ns/1ps
module tb_memory_writer_wiener;
  localparam int BS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_height = '0;
  logic [15:0] frame_width = '0;
  logic [31:0] base_addr_in = '0;
  logic        start_of_frame = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        frame_done;
  logic        write_error;

  memory_writer_wiener #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .frame_height(frame_height), .frame_width(frame_width),
    .base_addr_in(base_addr_in), .start_of_frame(start_of_frame), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .frame_done(frame_done),
    .write_error(write_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Slave / source state, all updated on the falling edge.
  int  cyc = 0;
  int  px_base = 0, src_idx = 0, src_len = 0;
  bit  gapped = 0, w_toggle = 0;
  int  aw_stall = 0, aw_wait = 0, err_burst = -1;
  bit  b_pend = 0, b_done = 0, err_seen = 0, prev_rst = 1;
  int  b_count = 0, fd_count = 0, b_at_fd = 0, acc_in_burst = 0, last_acc_cyc = -10;
  int  stab_viol = 0, lat_viol = 0, acc_viol = 0, dr_viol = 0, we_viol = 0;
  logic        p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0, p_wlast = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;
  logic [31:0] aw_q[$];
  logic [32:0] wd_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bvalid = 0; b_pend = 0; b_done = 0; err_seen = 0; acc_in_burst = 0;
      data_valid = 0; awready = 0; wready = 0; aw_wait = 0;
    end else begin
      if (!prev_rst) begin
        if (p_awvalid && !p_awready && (!awvalid || awaddr !== p_awaddr)) stab_viol++;
        if (p_wvalid && !p_wready && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) stab_viol++;
        if (write_error !== err_seen) we_viol++;
        if (data_ready && (awvalid || wvalid || bready)) dr_viol++;
        if (awvalid && !p_awvalid) begin
          if (cyc != last_acc_cyc + 1) lat_viol++;
          if (acc_in_burst != BS) acc_viol++;
          acc_in_burst = 0;
        end
        if (frame_done) begin fd_count++; b_at_fd = b_count; end
      end
      data_valid = (src_idx < src_len) && (!gapped || (cyc % 3) == 0);
      data_in    = 32'(px_base + src_idx);
      if (awvalid) begin
        if (aw_wait < aw_stall) begin awready = 0; aw_wait++; end
        else awready = 1;
      end else begin
        awready = (aw_stall == 0);
        aw_wait = 0;
      end
      wready = w_toggle ? ~wready : 1'b1;
      if (b_done) begin bvalid = 0; b_done = 0; end
      if (b_pend) begin
        bvalid = 1;
        bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
        b_pend = 0;
      end
      if (data_valid && data_ready) begin
        src_idx++;
        acc_in_burst++;
        if (acc_in_burst == BS) last_acc_cyc = cyc;
      end
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (wvalid && wready) begin
        wd_q.push_back({wlast, wdata});
        if (wlast) b_pend = 1;
      end
      if (bvalid && bready) begin
        b_count++;
        b_done = 1;
        if (bresp != 2'b00) err_seen = 1;
      end
    end
    prev_rst = rst;
    p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
    p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wlast = wlast;
  end

  task automatic setup(input logic [31:0] b, input int w, input int h, input int pxb,
                       input bit gap, input int aws, input bit wtg, input int errb);
    @(negedge clk);
    px_base = pxb; src_idx = 0; src_len = (w / BS) * (h / BS) * BS * BS;
    gapped = gap; aw_stall = aws; w_toggle = wtg; err_burst = errb;
    aw_q.delete(); wd_q.delete();
    b_count = 0; fd_count = 0; b_at_fd = -1;
    stab_viol = 0; lat_viol = 0; acc_viol = 0; dr_viol = 0; we_viol = 0;
    frame_width = 16'(w); frame_height = 16'(h); base_addr_in = b;
  endtask

  task automatic pulse_sof();
    @(negedge clk) start_of_frame = 1'b1;
    @(negedge clk) start_of_frame = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] b, input int w, input int h, input int pxb,
                           input bit gap, input int aws, input bit wtg, input int errb,
                           input string name);
    int bx, by, k;
    logic [31:0] exp_a;
    setup(b, w, h, pxb, gap, aws, wtg, errb);
    pulse_sof();
    for (int t = 0; t < 3000 && fd_count == 0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    check({name, " frame_done_count"}, fd_count, 1);
    bx = w / BS; by = h / BS;
    check({name, " bursts"}, aw_q.size(), bx * by * BS);
    check({name, " beats"}, wd_q.size(), bx * by * BS * BS);
    check({name, " bresps_at_done"}, b_at_fd, bx * by * BS);
    k = 0;
    for (int br = 0; br < by; br++)
      for (int bc = 0; bc < bx; bc++)
        for (int r = 0; r < BS; r++) begin
          exp_a = b + 32'(((br * BS + r) * w + bc * BS) * 4);
          check($sformatf("%s awaddr[%0d]", name, k),
                (k < aw_q.size()) ? aw_q[k] : 32'hdead_beef, exp_a);
          for (int c = 0; c < BS; c++)
            check($sformatf("%s beat[%0d][%0d]", name, k, c),
                  (k * BS + c < wd_q.size()) ? wd_q[k * BS + c] : 33'h0_dead_beef,
                  {c == BS - 1, 32'(pxb + k * BS + c)});
          k++;
        end
    check({name, " stall_stability"}, stab_viol, 0);
    check({name, " awvalid_latency"}, lat_viol, 0);
    check({name, " accepts_per_burst"}, acc_viol, 0);
    check({name, " data_ready_outside_fill"}, dr_viol, 0);
    check({name, " write_error_timing"}, we_viol, 0);
  endtask

  initial begin
    logic [31:0] mem [int];
    logic [31:0] got;
    bit found;
    repeat (3) @(negedge clk);
    check("reset flags", {data_ready, awvalid, wvalid, wlast, bready, frame_done, write_error}, 0);
    check("reset awaddr", awaddr, 0);
    check("reset wdata", wdata, 0);
    check("const awlen", awlen, 3);
    check("const awsize", awsize, 2);
    check("const awburst", awburst, 1);
    check("const wstrb", wstrb, 4'hf);
    @(negedge clk) rst = 1'b0;

    // 8x8 frame, index-valued pixels, slave always ready.
    run_frame(32'h0, 8, 8, 0, 0, 0, 0, -1, "t1");
    foreach (aw_q[k])
      for (int c = 0; c < BS; c++)
        if (k * BS + c < wd_q.size()) mem[int'(aw_q[k]) + c * 4] = wd_q[k * BS + c][31:0];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        got = mem.exists((r * 8 + c) * 4) ? mem[(r * 8 + c) * 4] : 32'hffff_ffff;
        check($sformatf("t1 mem[r%0d][c%0d]", r, c), got,
              32'(((r / 4) * 2 + c / 4) * 16 + (r % 4) * 4 + c % 4));
      end

    // Address stall then toggling wready.
    run_frame(32'h100, 8, 8, 1000, 0, 3, 1, -1, "t2");
    // Gapped input stream.
    run_frame(32'h200, 8, 8, 2000, 1, 0, 0, -1, "t3");
    // SLVERR on the fifth burst; frame must still complete.
    run_frame(32'h0, 8, 8, 3000, 0, 0, 0, 4, "t4");
    check("t4 write_error sticky", write_error, 1);

    // Zero width: immediate frame_done, no bursts.
    setup(32'h0, 0, 8, 0, 0, 0, 0, -1);
    pulse_sof();
    check("t5 frame_done next cycle", frame_done, 1);
    @(negedge clk);
    check("t5 frame_done single", frame_done, 0);
    repeat (10) @(negedge clk);
    check("t5 no bursts", aw_q.size(), 0);
    check("t5 write_error still set", write_error, 1);

    // Width 10 floors to two block columns; row stride 40 bytes.
    run_frame(32'h0, 10, 8, 4000, 0, 0, 0, -1, "t6");
    check("t6 second burst addr", (aw_q.size() > 1) ? aw_q[1] : 32'hdead_beef, 32'h28);

    // Reset during beat 2 of the first burst, then restart.
    setup(32'h800, 8, 8, 6000, 0, 0, 0, -1);
    pulse_sof();
    found = 0;
    for (int t = 0; t < 500 && !found; t++) begin
      @(negedge clk);
      if (wvalid && wdata == 32'(6000 + 2)) found = 1;
    end
    check("t7 reached beat 2", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t7 reset flags", {data_ready, awvalid, wvalid, wlast, bready, frame_done, write_error}, 0);
    check("t7 reset awaddr", awaddr, 0);
    check("t7 reset wdata", wdata, 0);
    @(negedge clk) rst = 1'b0;
    run_frame(32'h1000, 8, 8, 5000, 0, 0, 0, -1, "t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_writer_wiener.md
Name: memory_writer_wiener

Overview:
- Write-side counterpart of the noise-estimation memory reader.
- Accepts the Wiener filter's block-ordered pixel stream (BLOCK_SIZE x BLOCK_SIZE blocks, raster inside each block, blocks raster across the frame).
- Stores one block row at a time and writes it back to frame memory in raster layout.
- Each block row goes out as one AXI4 INCR write burst (AW/W/B channels) to the AXI memory slave.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, pixel word and AXI data width; one pixel per beat
BLOCK_SIZE, 4, block edge in pixels; burst length in beats (2..16)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_height  in  16  frame rows, sampled at start_of_frame
frame_width  in  16  frame columns, sampled at start_of_frame
base_addr_in  in  ADDR_WIDTH  frame byte base address, sampled at start_of_frame
start_of_frame  in  1  one-cycle pulse that arms a new frame
data_in  in  DATA_WIDTH  filtered pixel
data_valid  in  1  data_in valid
data_ready  out  1  writer accepts data_in this cycle
awaddr  out  ADDR_WIDTH  burst byte address
awlen  out  8  burst length minus 1
awsize  out  3  log2(DATA_WIDTH/8)
awburst  out  2  constant 2'b01 (INCR)
awvalid  out  1  write address valid
awready  in  1  slave accepts address
wdata  out  DATA_WIDTH  write beat data
wstrb  out  DATA_WIDTH/8  all ones
wlast  out  1  last beat of burst
wvalid  out  1  write data valid
wready  in  1  slave accepts beat
bresp  in  2  write response
bvalid  in  1  response valid
bready  out  1  writer accepts response
frame_done  out  1  one-cycle pulse after the last burst response of a frame
write_error  out  1  sticky; set on any bresp != 2'b00

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all counters 0; data_ready, awvalid, wvalid, wlast, bready, frame_done, write_error = 0; awaddr and wdata = 0.
- Reset mid-burst aborts immediately with no completion of outstanding beats.
- Constant outputs: awlen = BLOCK_SIZE-1, awsize = log2(DATA_WIDTH/8), awburst = 2'b01, wstrb = all ones.
- IDLE state:
  - On start_of_frame, latch base, height and width, and clear the block-row, block-column and row-in-block counters.
  - Go to FILL when both blocks_x = width/BLOCK_SIZE and blocks_y = height/BLOCK_SIZE are nonzero.
  - Otherwise pulse frame_done next cycle and stay in IDLE.
  - Non-multiple dimensions are floored; remainder pixels are never requested.
- FILL state:
  - data_ready = 1; each data_valid&&data_ready stores data_in into row buffer[idx], idx++.
  - On the BLOCK_SIZE-th accept, go to AW; awvalid = 1 in the next cycle.
  - awaddr = base + ((blk_row*BLOCK_SIZE + row_in_blk)*width + blk_col*BLOCK_SIZE) * (DATA_WIDTH/8).
  - Compute awaddr at ADDR_WIDTH with wrap-around modulo 2^ADDR_WIDTH.
- AW state: hold awvalid and awaddr stable until awready; on handshake go to W with beat=0.
- W state:
  - wvalid = 1 and wdata = buffer[beat]; wlast = (beat == BLOCK_SIZE-1).
  - Advance beat only on wready; wdata and wlast stay stable while stalled.
  - After the last-beat handshake go to B.
- B state:
  - bready = 1; on bvalid, set write_error if bresp != 0 (the frame continues).
  - Advance row_in_blk; on wrap to 0 advance blk_col; on blk_col wrap advance blk_row.
  - If blk_row wraps past blocks_y-1: frame_done = 1 for one cycle, go to IDLE. Otherwise go to FILL.
- data_ready = 0 outside FILL. No AW/W overlap; one outstanding burst at most.
- start_of_frame outside IDLE is ignored.
- write_error clears only on rst.

Test Plan:
- 8x8 frame, BLOCK_SIZE 4, base 0x0, pixel value = stream index 0..63, slaves always ready -> 16 bursts in this address order:
  - block 0: 0x00, 0x20, 0x40, 0x60
  - block 1: 0x10, 0x30, 0x50, 0x70
  - blocks 2 and 3: 0x80 .. 0xF0 by the same pattern
  - each burst has awlen=3, 4 beats, wlast on beat 3; memory word at row r, column c equals block-order pixel; frame_done pulses once after the 16th bvalid.
- awready low 3 cycles, then wready toggling 1/0 -> awaddr, wdata and wlast stable during stalls; 4 beats delivered in order; data_ready stays 0 until bvalid.
- data_valid gapped (1 of every 3 cycles) -> exactly 4 accepts per burst; awvalid asserts the cycle after the 4th accept.
- bresp=2'b10 on burst 5 -> write_error=1 from the next cycle and stays 1; remaining 11 bursts still issued; frame_done still pulses.
- frame_width=0 -> frame_done the cycle after start_of_frame; no awvalid. frame_width=10, height=8 -> floor to 2x2 blocks, 16 bursts, row stride 40 bytes (second burst at 0x28).
- rst asserted during W beat 2 -> next cycle all outputs 0 and IDLE; a new start_of_frame restarts at burst address base.
